// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect in, instruction BRAM read port, and the valid/ready
// output toward the decode skid buffer. master = fetch unit, slave = environment.
interface fetch_unit_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            imem_en_o;
    logic [XLEN-1:0] imem_addr_o;
    logic [ILEN-1:0] imem_rdata_i;
    logic            valid_out;
    logic            ready_in;
    logic [XLEN-1:0] pc_out;
    logic [ILEN-1:0] instr_out;

    modport master (
        input  redirect_valid_i, redirect_pc_i, imem_rdata_i, ready_in,
        output imem_en_o, imem_addr_o, valid_out, pc_out, instr_out
    );

    modport slave (
        output redirect_valid_i, redirect_pc_i, imem_rdata_i, ready_in,
        input  imem_en_o, imem_addr_o, valid_out, pc_out, instr_out
    );
endinterface

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a 2-entry {pc, instr} queue; issue-to-valid_out is 2 cycles.
// Reads are only issued when queue + in-flight has room, so a stall never loses data; redirect flushes.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_inflight;
    logic [XLEN-1:0] r_q_pc    [2];
    logic [ILEN-1:0] r_q_instr [2];
    logic            r_rd_ptr;
    logic            r_wr_ptr;
    logic [1:0]      r_count;

    logic [1:0]      w_occ;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_occ         = r_count + {1'b0, r_inflight};
    assign w_valid       = (r_count != 2'd0) && !bus.redirect_valid_i;
    assign w_pop         = w_valid && bus.ready_in;
    assign w_push        = r_inflight && !bus.redirect_valid_i;
    // A full pipe may still issue when the head leaves this cycle: that frees the slot the new read lands in.
    assign w_issue       = !rst && !bus.redirect_valid_i &&
                           ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));
    assign w_redirect_pc = bus.redirect_pc_i & {{(XLEN-2){1'b1}}, 2'b00};

    assign bus.imem_en_o   = w_issue;
    assign bus.imem_addr_o = r_pc;
    assign bus.valid_out   = w_valid;
    assign bus.pc_out      = (r_count != 2'd0) ? r_q_pc[r_rd_ptr]    : '0;
    assign bus.instr_out   = (r_count != 2'd0) ? r_q_instr[r_rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
            end
        end else if (bus.redirect_valid_i) begin
            // The read returning this cycle belongs to the old path and is dropped with the queue.
            r_pc       <= w_redirect_pc;
            r_inflight <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc          <= r_pc + XLEN'(4);
                r_inflight_pc <= r_pc;
            end
            if (w_push) begin
                r_q_pc[r_wr_ptr]    <= r_inflight_pc;
                r_q_instr[r_wr_ptr] <= bus.imem_rdata_i;
                r_wr_ptr            <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (w_push && !w_pop) |-> (r_count < 2'd2));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written redirect/reset/wrap sequences,
// then random ready/redirect traffic checked against a program-order stream model.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();

    fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory: word at byte address a holds a>>2, one-cycle read latency.
    initial bus.imem_rdata_i = '0;
    always @(posedge clk) begin
        if (bus.imem_en_o) bus.imem_rdata_i <= bus.imem_addr_o >> 2;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the next handshake and checks it; leaves time at posedge+1.
    task automatic expect_pop(input logic [31:0] exp, input bit toggle, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.valid_out && bus.ready_in) begin
                got = 1'b1;
                chk({nm, "_pc"}, bus.pc_out, exp);
                chk({nm, "_instr"}, bus.instr_out, exp >> 2);
            end
            cyc();
            if (toggle) bus.ready_in = ~bus.ready_in;
        end
        if (!got) chk({nm, "_timeout"}, 32'(got), 32'd1);
    endtask

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic        exp_en;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl [12];

    logic [31:0] m_issue_pc, m_out_pc;
    int          m_outstanding;
    bit          m_last_en;
    bit          e_valid, e_en, e_pop, redir;

    initial begin
        // Startup stream, then a 5-cycle stall starting at the third output (pc 0x8).
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h00, 32'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h00, 32'h04};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h00, 32'h08};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h04, 32'h0C};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h08, 32'h10};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h08, 32'h10};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h08, 32'h10};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h08, 32'h10};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h08, 32'h10};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h08, 32'h10};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h0C, 32'h14};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h10, 32'h18};

        rst                  = 1'b1;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = '0;
        bus.ready_in         = 1'b0;
        #2;
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_en",    32'(bus.imem_en_o), 32'd0);
        chk("rst_pc",    bus.pc_out,         32'd0);
        chk("rst_instr", bus.instr_out,      32'd0);
        chk("rst_addr",  bus.imem_addr_o,    32'd0);
        cyc();
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            bus.ready_in = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(bus.valid_out), 32'(tbl[i].exp_valid));
            chk($sformatf("vec%0d_en", i),    32'(bus.imem_en_o), 32'(tbl[i].exp_en));
            chk($sformatf("vec%0d_pc", i),    bus.pc_out,         tbl[i].exp_pc);
            chk($sformatf("vec%0d_instr", i), bus.instr_out,      tbl[i].exp_pc >> 2);
            chk($sformatf("vec%0d_addr", i),  bus.imem_addr_o,    tbl[i].exp_addr);
            cyc();
        end

        // Fill the queue, then redirect to an unaligned PC.
        bus.ready_in = 1'b0;
        repeat (2) begin @(negedge clk); cyc(); end
        @(negedge clk);
        chk("full_en", 32'(bus.imem_en_o), 32'd0);
        cyc();
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h103;
        bus.ready_in         = 1'b1;
        @(negedge clk);
        chk("redir_valid", 32'(bus.valid_out), 32'd0);
        chk("redir_en",    32'(bus.imem_en_o), 32'd0);
        cyc();
        bus.redirect_valid_i = 1'b0;
        @(negedge clk);
        chk("redir1_en",    32'(bus.imem_en_o), 32'd1);
        chk("redir1_addr",  bus.imem_addr_o,    32'h100);
        chk("redir1_valid", 32'(bus.valid_out), 32'd0);
        cyc();
        @(negedge clk);
        chk("redir2_valid", 32'(bus.valid_out), 32'd0);
        cyc();
        @(negedge clk);
        chk("redir3_valid", 32'(bus.valid_out), 32'd1);
        chk("redir3_pc",    bus.pc_out,         32'h100);
        cyc();
        expect_pop(32'h104, 1'b0, "redir_s1");
        expect_pop(32'h108, 1'b0, "redir_s2");

        // Back-to-back redirects with ready toggling: only the second target may appear.
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h200;
        bus.ready_in         = 1'b0;
        @(negedge clk);
        chk("b2b0_valid", 32'(bus.valid_out), 32'd0);
        cyc();
        bus.redirect_pc_i = 32'h300;
        bus.ready_in      = 1'b1;
        @(negedge clk);
        chk("b2b1_en", 32'(bus.imem_en_o), 32'd0);
        cyc();
        bus.redirect_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) expect_pop(32'h300 + 32'(4 * k), 1'b1, $sformatf("b2b_s%0d", k));

        // PC wrap-around.
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'hFFFF_FFF8;
        bus.ready_in         = 1'b1;
        @(negedge clk);
        cyc();
        bus.redirect_valid_i = 1'b0;
        expect_pop(32'hFFFF_FFF8, 1'b0, "wrap0");
        expect_pop(32'hFFFF_FFFC, 1'b0, "wrap1");
        expect_pop(32'h0000_0000, 1'b0, "wrap2");
        expect_pop(32'h0000_0004, 1'b0, "wrap3");

        // Asynchronous reset between edges while streaming.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.valid_out), 32'd0);
        chk("arst_en",    32'(bus.imem_en_o), 32'd0);
        chk("arst_addr",  bus.imem_addr_o,    32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        chk("arst_c0_en",    32'(bus.imem_en_o), 32'd1);
        chk("arst_c0_addr",  bus.imem_addr_o,    32'd0);
        chk("arst_c0_valid", 32'(bus.valid_out), 32'd0);
        cyc();
        @(negedge clk);
        chk("arst_c1_valid", 32'(bus.valid_out), 32'd0);
        cyc();
        @(negedge clk);
        chk("arst_c2_valid", 32'(bus.valid_out), 32'd1);
        chk("arst_c2_pc",    bus.pc_out,         32'd0);
        cyc();
        expect_pop(32'h4, 1'b0, "arst_s1");
        expect_pop(32'h8, 1'b0, "arst_s2");

        // Random traffic against a stream model: occupancy = issued - accepted since the last flush.
        for (int i = 0; i < 3000; i++) begin
            redir                = (i == 0) || ($urandom_range(0, 19) == 0);
            bus.redirect_valid_i = redir;
            bus.redirect_pc_i    = $urandom;
            bus.ready_in         = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e_valid = !redir && ((m_outstanding - int'(m_last_en)) > 0);
            e_pop   = e_valid && bus.ready_in;
            e_en    = !redir && ((m_outstanding < 2) || (m_outstanding == 2 && e_pop));
            if (i > 0) begin
                chk("rnd_valid", 32'(bus.valid_out), 32'(e_valid));
                chk("rnd_en",    32'(bus.imem_en_o), 32'(e_en));
                if (e_en) chk("rnd_addr", bus.imem_addr_o, m_issue_pc);
                if (e_pop) begin
                    chk("rnd_pc",    bus.pc_out,    m_out_pc);
                    chk("rnd_instr", bus.instr_out, m_out_pc >> 2);
                end
            end
            if (redir) begin
                m_issue_pc    = bus.redirect_pc_i & 32'hFFFF_FFFC;
                m_out_pc      = m_issue_pc;
                m_outstanding = 0;
                m_last_en     = 1'b0;
            end else begin
                m_outstanding = m_outstanding + int'(e_en) - int'(e_pop);
                if (e_en)  m_issue_pc = m_issue_pc + 32'd4;
                if (e_pop) m_out_pc   = m_out_pc + 32'd4;
                m_last_en = e_en;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
